// File: rtl/reflex_pkg.sv
// rtl/reflex_pkg.sv - shared game state type and timing defaults for the reflex round engine
package reflex_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        SHOW,
        DONE
    } game_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PLAY_TICKS = 99;
    localparam int DEF_SHOW_TICKS = 40;
    localparam int DEF_ROUNDS     = 4;
    localparam int DEF_TICK_DIV   = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/toggle_bank.sv
// rtl/toggle_bank.sv - per-button rising-edge detector feeding a toggle register
module toggle_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] presses,
    output logic [WIDTH-1:0] toggles,
    output logic [WIDTH-1:0] toggles_next
);

    logic [WIDTH-1:0] toggles_q;
    logic [WIDTH-1:0] toggles_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    // Only a 0->1 transition flips a button, so a held button toggles once.
    assign toggles_next = toggles_q ^ (presses & ~prev_q);
    assign toggles      = toggles_q;

    always_comb begin
        toggles_d = toggles_q;
        prev_d    = prev_q;
        if (clear) begin
            // Seed prev with the current levels so a button already held at
            // round start does not count as a press.
            toggles_d = '0;
            prev_d    = presses;
        end else if (en) begin
            toggles_d = toggles_next;
            prev_d    = presses;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            toggles_q <= '0;
            prev_q    <= '0;
        end else begin
            toggles_q <= toggles_d;
            prev_q    <= prev_d;
        end
    end

endmodule

// File: rtl/reflex_round_engine.sv
// rtl/reflex_round_engine.sv - multi-round reflex game FSM with tick prescaler, timer and scoring
module reflex_round_engine
    import reflex_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PLAY_TICKS = DEF_PLAY_TICKS,
    parameter int SHOW_TICKS = DEF_SHOW_TICKS,
    parameter int ROUNDS     = DEF_ROUNDS,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              code,
    input  logic [WIDTH-1:0]              presses,
    output logic [WIDTH-1:0]              lights,
    output logic                          correct_light,
    output logic                          incorrect_light,
    output logic [$clog2(ROUNDS+1)-1:0]   score,
    output logic                          busy,
    output logic                          done
);

    localparam int SW = $clog2(ROUNDS + 1);
    localparam int TW = $clog2(max_int(PLAY_TICKS, SHOW_TICKS) + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [TW-1:0]    PLAY_LAST  = TW'(PLAY_TICKS - 1);
    localparam logic [TW-1:0]    SHOW_LAST  = TW'(SHOW_TICKS - 1);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0]    ROUND_LAST = RW'(ROUNDS - 1);
    localparam logic [SW-1:0]    SCORE_MAX  = SW'(ROUNDS);
    localparam logic [WIDTH-1:0] SAFE_CODE  = WIDTH'(1);

    game_state_t      state_q, state_d;
    logic [WIDTH-1:0] stored_code_q, stored_code_d;
    logic [WIDTH-1:0] lights_q, lights_d;
    logic             correct_q, correct_d;
    logic             incorrect_q, incorrect_d;
    logic [SW-1:0]    score_q, score_d;
    logic [RW-1:0]    round_q, round_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tb_clear;
    logic             tb_en;
    logic [WIDTH-1:0] toggles;
    logic [WIDTH-1:0] toggles_next;
    logic             tick;
    logic             match;

    toggle_bank #(
        .WIDTH(WIDTH)
    ) u_toggle_bank (
        .clock       (clock),
        .rst_n       (rst_n),
        .clear       (tb_clear),
        .en          (tb_en),
        .presses     (presses),
        .toggles     (toggles),
        .toggles_next(toggles_next)
    );

    assign tick  = (presc_q == PRESC_LAST);
    // Evaluated on toggles_next so the completing press edge ends the round
    // on the same clock edge it is sampled.
    assign match = ((stored_code_q ^ toggles_next) == '0);

    always_comb begin
        state_d       = state_q;
        stored_code_d = stored_code_q;
        lights_d      = lights_q;
        correct_d     = correct_q;
        incorrect_d   = incorrect_q;
        score_d       = score_q;
        round_d       = round_q;
        timer_d       = timer_q;
        presc_d       = presc_q;
        tb_clear      = 1'b0;
        tb_en         = 1'b0;

        if (start) begin
            state_d = LOAD;
            score_d = '0;
            round_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    // A zero target would be matched before any press.
                    stored_code_d = (code == '0) ? SAFE_CODE : code;
                    tb_clear      = 1'b1;
                    timer_d       = '0;
                    presc_d       = '0;
                    state_d       = PLAY;
                end
                PLAY: begin
                    tb_en    = 1'b1;
                    lights_d = stored_code_q ^ toggles_next;
                    presc_d  = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        timer_d = timer_q + TW'(1);
                    end
                    if (match) begin
                        state_d   = SHOW;
                        correct_d = 1'b1;
                        score_d   = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + SW'(1);
                        timer_d   = '0;
                        presc_d   = '0;
                    end else if (tick && (timer_q == PLAY_LAST)) begin
                        state_d     = SHOW;
                        incorrect_d = 1'b1;
                        timer_d     = '0;
                        presc_d     = '0;
                    end
                end
                SHOW: begin
                    // The toggle bank is frozen here, so this repeats the last PLAY pattern.
                    lights_d = stored_code_q ^ toggles;
                    presc_d  = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        timer_d = timer_q + TW'(1);
                        if (timer_q == SHOW_LAST) begin
                            timer_d = '0;
                            if (round_q == ROUND_LAST) begin
                                state_d = DONE;
                            end else begin
                                round_d = round_q + RW'(1);
                                state_d = LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d != SHOW) begin
            correct_d   = 1'b0;
            incorrect_d = 1'b0;
        end
        if ((state_d == DONE) || (state_d == IDLE)) begin
            lights_d = '0;
        end
        busy_d = (state_d == LOAD) || (state_d == PLAY) || (state_d == SHOW);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            stored_code_q <= '0;
            lights_q      <= '0;
            correct_q     <= 1'b0;
            incorrect_q   <= 1'b0;
            score_q       <= '0;
            round_q       <= '0;
            timer_q       <= '0;
            presc_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stored_code_q <= stored_code_d;
            lights_q      <= lights_d;
            correct_q     <= correct_d;
            incorrect_q   <= incorrect_d;
            score_q       <= score_d;
            round_q       <= round_d;
            timer_q       <= timer_d;
            presc_q       <= presc_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign lights          = lights_q;
    assign correct_light   = correct_q;
    assign incorrect_light = incorrect_q;
    assign score           = score_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_reflex_round_engine.sv
// tb/tb_reflex_round_engine.sv - randomized self-checking bench for reflex_round_engine
module tb_reflex_round_engine;

    localparam int PT = 10;
    localparam int ST = 4;
    localparam int RN = 2;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_PLAY = 2;
    localparam int P_SHOW = 3;
    localparam int P_DONE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] code;
    logic [7:0] presses;

    logic [7:0] o_lights [2];
    logic       o_cor    [2];
    logic       o_inc    [2];
    logic [1:0] o_score  [2];
    logic       o_busy   [2];
    logic       o_done   [2];

    always #5 clk = ~clk;

    reflex_round_engine #(
        .WIDTH(8), .PLAY_TICKS(PT), .SHOW_TICKS(ST), .ROUNDS(RN), .TICK_DIV(1)
    ) dut_div1 (
        .clock          (clk),
        .rst_n          (rst_n),
        .start          (start),
        .code           (code),
        .presses        (presses),
        .lights         (o_lights[0]),
        .correct_light  (o_cor[0]),
        .incorrect_light(o_inc[0]),
        .score          (o_score[0]),
        .busy           (o_busy[0]),
        .done           (o_done[0])
    );

    reflex_round_engine #(
        .WIDTH(8), .PLAY_TICKS(PT), .SHOW_TICKS(ST), .ROUNDS(RN), .TICK_DIV(3)
    ) dut_div3 (
        .clock          (clk),
        .rst_n          (rst_n),
        .start          (start),
        .code           (code),
        .presses        (presses),
        .lights         (o_lights[1]),
        .correct_light  (o_cor[1]),
        .incorrect_light(o_inc[1]),
        .score          (o_score[1]),
        .busy           (o_busy[1]),
        .done           (o_done[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Game-level reference: each phase is measured in whole clock cycles
    // (ticks * divider), toggles are a plain bit vector of pressed buttons.
    int         m_phase  [2];
    int         m_cnt    [2];
    logic [7:0] m_stored [2];
    logic [7:0] m_tog    [2];
    logic [7:0] m_prev   [2];
    logic [7:0] m_lights [2];
    int         m_score  [2];
    int         m_round  [2];
    bit         m_cor    [2];
    bit         m_inc    [2];

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k]  = P_IDLE;
            m_cnt[k]    = 0;
            m_stored[k] = 8'h00;
            m_tog[k]    = 8'h00;
            m_prev[k]   = 8'h00;
            m_lights[k] = 8'h00;
            m_score[k]  = 0;
            m_round[k]  = 0;
            m_cor[k]    = 1'b0;
            m_inc[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit st, input logic [7:0] cd, input logic [7:0] pr);
        if (st) begin
            m_phase[k] = P_LOAD;
            m_score[k] = 0;
            m_round[k] = 0;
            m_cor[k]   = 1'b0;
            m_inc[k]   = 1'b0;
        end else if (m_phase[k] == P_LOAD) begin
            m_stored[k] = (cd == 8'h00) ? 8'h01 : cd;
            m_tog[k]    = 8'h00;
            m_prev[k]   = pr;
            m_cnt[k]    = 0;
            m_phase[k]  = P_PLAY;
        end else if (m_phase[k] == P_PLAY) begin
            m_tog[k]    = m_tog[k] ^ (pr & ~m_prev[k]);
            m_prev[k]   = pr;
            m_lights[k] = m_stored[k] ^ m_tog[k];
            m_cnt[k]++;
            if (m_lights[k] == 8'h00) begin
                m_phase[k] = P_SHOW;
                m_cor[k]   = 1'b1;
                m_score[k] = (m_score[k] + 1 > RN) ? RN : m_score[k] + 1;
                m_cnt[k]   = 0;
            end else if (m_cnt[k] == PT * div_of(k)) begin
                m_phase[k] = P_SHOW;
                m_inc[k]   = 1'b1;
                m_cnt[k]   = 0;
            end
        end else if (m_phase[k] == P_SHOW) begin
            m_cnt[k]++;
            if (m_cnt[k] == ST * div_of(k)) begin
                m_cor[k] = 1'b0;
                m_inc[k] = 1'b0;
                m_cnt[k] = 0;
                if (m_round[k] == RN - 1) begin
                    m_phase[k]  = P_DONE;
                    m_lights[k] = 8'h00;
                end else begin
                    m_round[k]++;
                    m_phase[k] = P_LOAD;
                end
            end
        end
    endtask

    task automatic compare_all(input string ph);
        for (int k = 0; k < 2; k++) begin
            if (m_phase[k] != P_LOAD)
                check_val($sformatf("%s/d%0d/lights", ph, k), 32'(o_lights[k]), 32'(m_lights[k]));
            check_val($sformatf("%s/d%0d/correct", ph, k), 32'(o_cor[k]), 32'(m_cor[k]));
            check_val($sformatf("%s/d%0d/incorrect", ph, k), 32'(o_inc[k]), 32'(m_inc[k]));
            check_val($sformatf("%s/d%0d/score", ph, k), 32'(o_score[k]), 32'(m_score[k]));
            check_val($sformatf("%s/d%0d/busy", ph, k), 32'(o_busy[k]),
                      32'((m_phase[k] >= P_LOAD) && (m_phase[k] <= P_SHOW)));
            check_val($sformatf("%s/d%0d/done", ph, k), 32'(o_done[k]), 32'(m_phase[k] == P_DONE));
        end
    endtask

    task automatic step(input bit st, input logic [7:0] cd, input logic [7:0] pr, input string ph);
        @(negedge clk);
        start   = st;
        code    = cd;
        presses = pr;
        for (int k = 0; k < 2; k++) model_step(k, st, cd, pr);
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic async_reset(input string ph);
        @(negedge clk);
        #2;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(ph);
        check_val({ph, "/busy0_now"}, 32'(o_busy[0]), 32'd0);
        check_val({ph, "/lights0_now"}, 32'(o_lights[0]), 32'd0);
        @(posedge clk);
        #1;
        compare_all(ph);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] pr;
    logic [7:0] lit;
    int         r;
    int         idx;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        code    = 8'h00;
        presses = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (6) step(1'b0, 8'($urandom), 8'($urandom), "idle");

        // round 1 matched: 05 -> 04 -> 00
        step(1'b1, 8'h05, 8'h00, "t2");
        step(1'b0, 8'h05, 8'h00, "t2");
        step(1'b0, 8'h11, 8'h00, "t2");
        check_val("t2_lights_a", 32'(o_lights[0]), 32'h05);
        step(1'b0, 8'h22, 8'h01, "t2");
        check_val("t2_lights_b", 32'(o_lights[0]), 32'h04);
        step(1'b0, 8'h33, 8'h04, "t2");
        check_val("t2_lights_c", 32'(o_lights[0]), 32'h00);
        check_val("t2_correct", 32'(o_cor[0]), 32'd1);
        check_val("t2_score", 32'(o_score[0]), 32'd1);
        repeat (3) step(1'b0, 8'h44, 8'h00, "t2");
        check_val("t2_show_held", 32'(o_cor[0]), 32'd1);
        step(1'b0, 8'h44, 8'h00, "t2");
        check_val("t2_show_end", 32'(o_cor[0]), 32'd0);

        // round 2 timed out, then DONE
        step(1'b0, 8'h3c, 8'h00, "t3");
        repeat (9) step(1'b0, 8'($urandom), 8'h00, "t3");
        check_val("t3_not_yet", 32'(o_inc[0]), 32'd0);
        step(1'b0, 8'($urandom), 8'h00, "t3");
        check_val("t3_timeout", 32'(o_inc[0]), 32'd1);
        repeat (4) step(1'b0, 8'($urandom), 8'h00, "t3");
        check_val("t3_done", 32'(o_done[0]), 32'd1);
        check_val("t3_score", 32'(o_score[0]), 32'd1);
        check_val("t3_lights", 32'(o_lights[0]), 32'd0);
        repeat (70) step(1'b0, 8'($urandom), 8'h00, "t3");
        check_val("t3_div3_done", 32'(o_done[1]), 32'd1);
        check_val("t3_div3_score", 32'(o_score[1]), 32'd1);

        // zero code becomes 01
        step(1'b1, 8'h00, 8'h00, "t4");
        step(1'b0, 8'h00, 8'h00, "t4");
        step(1'b0, 8'h77, 8'h01, "t4");
        check_val("t4_lights", 32'(o_lights[0]), 32'h00);
        check_val("t4_correct", 32'(o_cor[0]), 32'd1);
        check_val("t4_correct_div3", 32'(o_cor[1]), 32'd1);

        // restart mid-PLAY, then reset mid-SHOW
        repeat (4) step(1'b0, 8'ha5, 8'h00, "t5");
        step(1'b0, 8'ha5, 8'h00, "t5");
        repeat (3) step(1'b0, 8'ha5, 8'h00, "t5");
        check_val("t5_score_before", 32'(o_score[0]), 32'd1);
        step(1'b1, 8'h00, 8'h00, "t5");
        check_val("t5_score_cleared", 32'(o_score[0]), 32'd0);
        check_val("t5_busy", 32'(o_busy[0]), 32'd1);
        step(1'b0, 8'h5a, 8'h00, "t5");
        step(1'b0, 8'h5a, 8'h00, "t5");
        check_val("t5_new_code", 32'(o_lights[0]), 32'h5a);
        repeat (9) step(1'b0, 8'h5a, 8'h00, "t5");
        check_val("t5_in_show", 32'(o_inc[0]), 32'd1);
        repeat (2) step(1'b0, 8'h5a, 8'h00, "t5");
        async_reset("t5_rst");
        check_val("t5_inc_cleared", 32'(o_inc[0]), 32'd0);

        // divider 3: held button toggles once, timeout after 30 cycles
        step(1'b1, 8'h00, 8'h00, "t6");
        step(1'b0, 8'h80, 8'h00, "t6");
        repeat (20) step(1'b0, 8'($urandom), 8'h01, "t6");
        check_val("t6_held_once", 32'(o_lights[1]), 32'h81);
        repeat (9) step(1'b0, 8'($urandom), 8'h00, "t6");
        check_val("t6_not_yet", 32'(o_inc[1]), 32'd0);
        step(1'b0, 8'($urandom), 8'h00, "t6");
        check_val("t6_timeout", 32'(o_inc[1]), 32'd1);

        // randomized play driven toward matches using the model's lights
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 299);
            if (r == 0) begin
                async_reset("rnd_rst");
            end else begin
                r   = $urandom_range(0, 9);
                lit = m_lights[0];
                if (r < 4 || lit == 8'h00) begin
                    pr = 8'h00;
                end else if (r < 8) begin
                    idx = $urandom_range(0, 7);
                    while (!lit[idx]) idx = (idx + 1) % 8;
                    pr = 8'h01 << idx;
                end else begin
                    pr = 8'($urandom);
                end
                step(($urandom_range(0, 79) == 0),
                     ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                     pr, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
